// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit:
// op encodings, FSM states and the default bus timeout.
package lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP,
        S_FAULT
    } lsu_state_e;

    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: enables, store replication,
// load extraction with extension, and the alignment check.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  bus_be,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata,
    output logic        misaligned
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = bus_rdata[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    end

    always_comb begin
        bus_be     = 4'b0000;
        wdata_rep  = 32'h0;
        ldata      = 32'h0;
        misaligned = 1'b0;
        unique case (mem_op)
            OP_LW, OP_SW: begin
                bus_be     = 4'b1111;
                wdata_rep  = wdata;
                ldata      = bus_rdata;
                misaligned = |offset;
            end
            OP_LH, OP_LHU, OP_SH: begin
                bus_be     = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep  = {2{wdata[15:0]}};
                ldata      = (mem_op == OP_LH) ?
                             {{16{lane_h[15]}}, lane_h} :
                             {16'h0, lane_h};
                misaligned = offset[0];
            end
            default: begin
                bus_be     = 4'b0001 << offset;
                wdata_rep  = {4{wdata[7:0]}};
                ldata      = (mem_op == OP_LB) ?
                             {{24{lane_b[7]}}, lane_b} :
                             {24'h0, lane_b};
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one request/ack bus transaction
// per accepted op, with alignment faults and a bounded wait.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        to_q, to_d;
    logic [31:0] rdata_q, rdata_d;

    logic [2:0]  al_op;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_ldata;
    logic        al_mis;
    logic        expired;

    // In IDLE the aligner checks the incoming op; otherwise the latched one.
    always_comb begin
        al_op  = (state_q == S_IDLE) ? mem_op : op_q;
        al_off = (state_q == S_IDLE) ? addr[1:0] : addr_q[1:0];
    end

    lsu_lane_align u_align (
        .mem_op     (al_op),
        .offset     (al_off),
        .wdata      (wdata_q),
        .bus_rdata  (bus_rdata),
        .bus_be     (al_be),
        .wdata_rep  (al_wdata),
        .ldata      (al_ldata),
        .misaligned (al_mis)
    );

    assign expired = (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= 3'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 8'h0;
            to_q    <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = al_mis ? S_FAULT : S_BUS;
            end
            S_BUS: begin
                if (bus_ack || expired) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        rdata_d = rdata_q;
        if (state_q == S_IDLE && start && !al_mis) begin
            op_d    = mem_op;
            addr_d  = addr;
            wdata_d = wdata;
            cnt_d   = 8'h0;
            to_d    = 1'b0;
        end
        // Ack wins over an expiring counter in the same cycle.
        if (state_q == S_BUS) begin
            if (bus_ack) begin
                if (!is_store(op_q)) rdata_d = al_ldata;
            end else if (expired) begin
                to_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_RESP) || (state_q == S_FAULT);
        misaligned = (state_q == S_FAULT);
        timeout    = (state_q == S_RESP) && to_q;
        rdata      = rdata_q;
        bus_req    = (state_q == S_BUS);
        bus_we     = bus_req && is_store(op_q);
        bus_addr   = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
        bus_be     = bus_req ? al_be : 4'b0000;
        bus_wdata  = bus_req ? al_wdata : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit with a
// behavioural byte-lane model and a cycle-driven slave.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mem_op = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misaligned, timeout;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done),
        .rdata(rdata), .misaligned(misaligned), .timeout(timeout),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model (byte-oriented, from the lane rules)
    logic [31:0] ref_rdata = 32'h0;

    function automatic int op_size(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd5) return 4;
        if (op == 3'd1 || op == 3'd2 || op == 3'd6) return 2;
        return 1;
    endfunction

    function automatic bit op_store(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    function automatic bit op_signed(input logic [2:0] op);
        return op == 3'd1 || op == 3'd3;
    endfunction

    function automatic bit m_mis(input logic [2:0] op, input logic [31:0] a);
        return (a % op_size(op)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] op, input logic [31:0] a);
        int s = op_size(op);
        return 4'(((1 << s) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] r = 0;
        int s = op_size(op);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % s) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] w);
        int s = op_size(op);
        longint v = (longint'(w) >> (8 * (a % 4))) & ((64'd1 << (8 * s)) - 1);
        if (op_signed(op) && v >= (64'd1 << (8 * s - 1))) v = v - (64'd1 << (8 * s));
        return v[31:0];
    endfunction

    // Observations from one transaction
    int          obs_lat, obs_reqc;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_tmo, obs_mis, obs_stable, obs_zero, obs_idle;

    // waitc < 0: slave never acks
    task automatic do_txn(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input int waitc,
                          input logic [31:0] rw);
        @(negedge clk);
        start = 1'b1; mem_op = op; addr = a; wdata = wd;
        obs_lat = -1; obs_reqc = 0; obs_addr = 0; obs_be = 0;
        obs_we = 0; obs_wdata = 0; obs_tmo = 0; obs_mis = 0;
        obs_rdata = 0; obs_stable = 1; obs_zero = 1; obs_idle = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0; bus_ack = 1'b0; bus_rdata = $urandom;
            if (bus_req) begin
                if (obs_reqc == 0) begin
                    obs_addr = bus_addr; obs_be = bus_be;
                    obs_we = bus_we; obs_wdata = bus_wdata;
                end else if (bus_addr !== obs_addr || bus_be !== obs_be ||
                             bus_we !== obs_we || bus_wdata !== obs_wdata) begin
                    obs_stable = 0;
                end
                if (waitc >= 0 && obs_reqc == waitc) begin
                    bus_ack = 1'b1; bus_rdata = rw;
                end
                obs_reqc++;
            end else if (bus_we || bus_addr != 0 || bus_be != 0 || bus_wdata != 0) begin
                obs_zero = 0;
            end
            if (done) begin
                obs_lat = k; obs_tmo = timeout;
                obs_mis = misaligned; obs_rdata = rdata;
                break;
            end
        end
        @(negedge clk);
        bus_ack = 1'b0;
        obs_idle = !busy && !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({busy, done, misaligned, timeout, bus_req, bus_we} !== 6'b0 ||
            rdata !== 0 || bus_addr !== 0 || bus_be !== 0 || bus_wdata !== 0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b req=%b rdata=%h want all zero",
                     busy, done, bus_req, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lb();
        do_txn(3'd3, 32'h1003, 32'h0, 1, 32'h80FF_1234);
        ref_rdata = 32'hFFFF_FF80;
        checks++;
        if (obs_addr !== 32'h1000 || obs_be !== 4'b1000) begin
            errors++;
            $display("FAIL lb_bus: addr=%h be=%b want 00001000 1000", obs_addr, obs_be);
        end
        checks++;
        if (obs_rdata !== 32'hFFFF_FF80 || obs_lat !== 3) begin
            errors++;
            $display("FAIL lb_data: rdata=%h lat=%0d want ffffff80 3", obs_rdata, obs_lat);
        end
    endtask

    task automatic test_lhu();
        do_txn(3'd2, 32'h2002, 32'h0, 0, 32'hBEEF_0000);
        ref_rdata = 32'h0000_BEEF;
        checks++;
        if (obs_be !== 4'b1100 || obs_rdata !== 32'h0000_BEEF || obs_lat !== 2) begin
            errors++;
            $display("FAIL lhu: be=%b rdata=%h lat=%0d want 1100 0000beef 2",
                     obs_be, obs_rdata, obs_lat);
        end
    endtask

    task automatic test_sb();
        do_txn(3'd7, 32'h10, 32'h1234_56AB, 0, 32'h5555_5555);
        checks++;
        if (obs_we !== 1'b1 || obs_be !== 4'b0001 || obs_wdata !== 32'hABAB_ABAB) begin
            errors++;
            $display("FAIL sb_bus: we=%b be=%b wdata=%h want 1 0001 abababab",
                     obs_we, obs_be, obs_wdata);
        end
        checks++;
        if (obs_rdata !== ref_rdata) begin
            errors++;
            $display("FAIL sb_rdata: rdata=%h want %h", obs_rdata, ref_rdata);
        end
    endtask

    task automatic test_misaligned();
        do_txn(3'd0, 32'h0006, 32'h0, 0, 32'h0);
        checks++;
        if (obs_lat !== 1 || obs_mis !== 1'b1 || obs_reqc !== 0 || obs_tmo !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: lat=%0d mis=%b reqs=%0d want 1 1 0",
                     obs_lat, obs_mis, obs_reqc);
        end
        checks++;
        if (obs_rdata !== ref_rdata || !obs_idle) begin
            errors++;
            $display("FAIL misaligned_after: rdata=%h idle=%b want %h 1",
                     obs_rdata, obs_idle, ref_rdata);
        end
    endtask

    task automatic test_timeout();
        do_txn(3'd5, 32'h80, 32'hCAFE_F00D, -1, 32'h0);
        checks++;
        if (obs_reqc !== 4 || obs_lat !== 5 || obs_tmo !== 1'b1 || obs_mis !== 1'b0) begin
            errors++;
            $display("FAIL timeout: reqs=%0d lat=%0d tmo=%b want 4 5 1",
                     obs_reqc, obs_lat, obs_tmo);
        end
        checks++;
        if (!obs_idle || obs_rdata !== ref_rdata || !obs_stable) begin
            errors++;
            $display("FAIL timeout_after: idle=%b stable=%b rdata=%h want 1 1 %h",
                     obs_idle, obs_stable, obs_rdata, ref_rdata);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; mem_op = 3'd0; addr = 32'h6;
        @(negedge clk);
        mem_op = 3'd0; addr = 32'h40;
        checks++;
        if (!done || !misaligned) begin
            errors++;
            $display("FAIL b2b_fault: done=%b mis=%b want 1 1", done, misaligned);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b want 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h40) begin
            errors++;
            $display("FAIL b2b_accept: req=%b addr=%h want 1 00000040", bus_req, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
        ref_rdata = 32'h1357_9BDF;
        @(negedge clk);
        bus_ack = 1'b0;
        checks++;
        if (!done || rdata !== ref_rdata) begin
            errors++;
            $display("FAIL b2b_done: done=%b rdata=%h want 1 %h", done, rdata, ref_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op = 3'($urandom);
            logic [31:0] a = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rw = $urandom;
            int          w = int'($urandom_range(0, 4));
            bit          mis;
            int          e_lat, e_req;
            if (w == 4) w = -1;
            if (n % 3 == 0) a[1:0] = 2'b00;
            mis = m_mis(op, a);
            do_txn(op, a, wd, w, rw);
            if (mis) begin e_lat = 1; e_req = 0; end
            else if (w < 0) begin e_lat = 5; e_req = 4; end
            else begin e_lat = w + 2; e_req = w + 1; end
            if (!mis && w >= 0 && !op_store(op)) ref_rdata = m_ld(op, a, rw);
            checks++;
            if (obs_lat !== e_lat || obs_reqc !== e_req || obs_mis !== mis ||
                obs_tmo !== (!mis && w < 0)) begin
                errors++;
                $display("FAIL rnd_flow[%0d]: op=%0d a=%h lat=%0d req=%0d mis=%b tmo=%b want %0d %0d %b %b",
                         n, op, a, obs_lat, obs_reqc, obs_mis, obs_tmo,
                         e_lat, e_req, mis, !mis && w < 0);
            end
            if (!mis) begin
                checks++;
                if (obs_addr !== {a[31:2], 2'b00} || obs_be !== m_be(op, a) ||
                    obs_we !== op_store(op) || obs_wdata !== m_wd(op, wd)) begin
                    errors++;
                    $display("FAIL rnd_bus[%0d]: op=%0d addr=%h be=%b we=%b wd=%h want %h %b %b %h",
                             n, op, obs_addr, obs_be, obs_we, obs_wdata,
                             {a[31:2], 2'b00}, m_be(op, a), op_store(op), m_wd(op, wd));
                end
            end
            checks++;
            if (obs_rdata !== ref_rdata) begin
                errors++;
                $display("FAIL rnd_rdata[%0d]: op=%0d a=%h rdata=%h want %h",
                         n, op, a, obs_rdata, ref_rdata);
            end
            checks++;
            if (!obs_stable || !obs_zero || !obs_idle) begin
                errors++;
                $display("FAIL rnd_hold[%0d]: stable=%b zero=%b idle=%b want 1 1 1",
                         n, obs_stable, obs_zero, obs_idle);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; mem_op = 3'd0; addr = 32'h100; wdata = 32'h0;
        @(negedge clk);
        addr = 32'h200;
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h100) begin
            errors++;
            $display("FAIL ignore_start: req=%b addr=%h want 1 00000100", bus_req, bus_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || rdata !== 0) begin
            errors++;
            $display("FAIL async_reset: req=%b busy=%b rdata=%h want 0 0 0",
                     bus_req, busy, rdata);
        end
        ref_rdata = 32'h0;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus_ack = (k >= 2);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || bus_req !== 1'b0) begin
                errors++;
                $display("FAIL post_reset[%0d]: busy=%b done=%b req=%b want 0 0 0",
                         k, busy, done, bus_req);
            end
        end
        @(negedge clk);
        bus_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu();
        test_sb();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
